// File: rtl/regfile_pkg.sv
// Shared types and default constants for the scoreboarded register file.
// The address-width helper keeps port widths and storage depth consistent.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int                    DEF_DATA_W  = 32;
   localparam int                    DEF_NREGS   = 32;
   localparam int                    DEF_SP_REG  = 29;
   localparam logic [DEF_DATA_W-1:0] DEF_SP_INIT = 32'h0000_2FFC;

   // Degenerate depths still get a 1-bit address so port slices stay legal.
   function automatic int aw_of(input int nregs);
      return (nregs <= 1) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read path: zero-register forcing, write-back bypass and
// busy masking. Outputs are parked at data=0 / busy=1 while the sweep runs.
module regfile_sb_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              run,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] rh_data,
   input  logic              rh_busy,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data,
   output logic              busy
);

   logic wr_hit;

   // NOTE: every output gets a default before any branch, so no path can
   // leave it unassigned and no latch is inferred.
   always_comb begin
      data   = rh_data;
      busy   = rh_busy;
      wr_hit = wr_en && (wr_addr == addr);
      if (!run) begin
         data = '0;
         busy = 1'b1;
      end else if (ZERO_REG && (addr == '0)) begin
         data = '0;
         busy = 1'b0;
      end else if (wr_hit) begin
         // The write-back lands this cycle, so the operand is already valid.
         data = wr_data;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: storage, post-reset clear sweep, pending-write
// scoreboard, NRD bypassed read ports and a registered debug read port.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                NREGS    = DEF_NREGS,
   parameter int                NRD      = 2,
   parameter bit                ZERO_REG = 1'b1,
   parameter int                SP_REG   = DEF_SP_REG,
   parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(DEF_SP_INIT),
   localparam int               AW       = aw_of(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_addr,
   input  logic [AW-1:0]         dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   typedef logic [DATA_W-1:0] word_t;

   state_e            state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   word_t             rh_q [NREGS];
   word_t             rh_d [NREGS];
   word_t             dbg_data_q, dbg_data_d;
   logic              run;

   assign run      = (state_q == RUN);
   assign ready    = run;
   assign dbg_data = dbg_data_q;

   // Sweep: ptr stops on the last index instead of wrapping.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (!run) begin
         if (ptr_q == AW'(NREGS - 1)) begin
            state_d = RUN;
         end else begin
            ptr_d = ptr_q + AW'(1);
         end
      end
   end

   always_comb begin
      rh_d = rh_q;
      if (!run) begin
         rh_d[ptr_q] = (ptr_q == AW'(SP_REG)) ? SP_INIT : '0;
      end else if (wr_en && !(ZERO_REG && (wr_addr == '0))) begin
         rh_d[wr_addr] = wr_data;
      end
   end

   // Issue beats write-back, so a new in-flight writer keeps the entry busy.
   always_comb begin
      busy_d = busy_q;
      if (!run) begin
         busy_d = '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (iss_en && (iss_addr == AW'(r)) && !(ZERO_REG && (r == 0))) begin
               busy_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
               busy_d[r] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      dbg_data_d = run ? rh_q[dbg_addr] : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values. The storage array is deliberately left out of
   // reset; the sweep initialises it, keeping the array reset-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         ptr_q      <= '0;
         busy_q     <= '0;
         dbg_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         dbg_data_q <= dbg_data_d;
         rh_q       <= rh_d;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[i*AW +: AW];

      regfile_sb_rdport #(
         .DATA_W   (DATA_W),
         .AW       (AW),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .run     (run),
         .addr    (addr),
         .rh_data (rh_q[addr]),
         .rh_busy (busy_q[addr]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .data    (rd_data[i*DATA_W +: DATA_W]),
         .busy    (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default configuration plus a small
// 8-register, 3-port, no-zero-register configuration.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Default instance: DATA_W=32, NREGS=32, NRD=2, AW=5
   logic        rst_n;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   regfile_sb u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Small instance: NREGS=8, NRD=3, ZERO_REG=0, SP_REG=2, AW=3
   logic        b_rst_n;
   logic        b_ready;
   logic [8:0]  b_rd_addr;
   logic [95:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic        b_wr_en;
   logic [2:0]  b_wr_addr;
   logic [31:0] b_wr_data;
   logic        b_iss_en;
   logic [2:0]  b_iss_addr;
   logic [2:0]  b_dbg_addr;
   logic [31:0] b_dbg_data;

   regfile_sb #(
      .NREGS    (8),
      .NRD      (3),
      .ZERO_REG (1'b0),
      .SP_REG   (2)
   ) u_dut_b (
      .clk      (clk),
      .rst_n    (b_rst_n),
      .ready    (b_ready),
      .rd_addr  (b_rd_addr),
      .rd_data  (b_rd_data),
      .rd_busy  (b_rd_busy),
      .wr_en    (b_wr_en),
      .wr_addr  (b_wr_addr),
      .wr_data  (b_wr_data),
      .iss_en   (b_iss_en),
      .iss_addr (b_iss_addr),
      .dbg_addr (b_dbg_addr),
      .dbg_data (b_dbg_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", ready);
      end
      n_tests++;
      if (rd_busy !== 2'b11) begin
         n_fail++; $display("FAIL reset_rd_busy: got %b want 11", rd_busy);
      end
      n_tests++;
      if (rd_data !== 64'h0) begin
         n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
      end
      n_tests++;
      if (dbg_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_dbg: got %h want 0", dbg_data);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         tick();
         n_tests++;
         if (ready !== (e == 32)) begin
            n_fail++; $display("FAIL sweep_ready edge %0d: got %b want %b", e, ready, (e == 32));
         end
      end
      rd_addr = {5'd5, 5'd29};
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h0000_2FFC) begin
         n_fail++; $display("FAIL init_r29: got %h want 00002ffc", rd_data[31:0]);
      end
      n_tests++;
      if (rd_data[63:32] !== 32'h0) begin
         n_fail++; $display("FAIL init_r5: got %h want 0", rd_data[63:32]);
      end
      n_tests++;
      if (rd_busy !== 2'b00) begin
         n_fail++; $display("FAIL init_busy: got %b want 00", rd_busy);
      end
      rd_addr = {5'd31, 5'd31};
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL init_r31: got %h want 0", rd_data[31:0]);
      end
   endtask

   task automatic test_write_zero();
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hDEAD_BEEF;
      tick();
      wr_en = 1'b0;
      rd_addr = {5'd10, 5'd0};
      #1;
      n_tests++;
      if (rd_data[63:32] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL write_r10_p1: got %h want deadbeef", rd_data[63:32]);
      end
      // Zero register must stay zero even while being written and bypassed.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
      rd_addr = {5'd0, 5'd0};
      dbg_addr = 5'd0;
      #1;
      n_tests++;
      if (rd_data !== 64'h0) begin
         n_fail++; $display("FAIL r0_no_bypass: got %h want 0", rd_data);
      end
      tick();
      wr_en = 1'b0;
      #1;
      n_tests++;
      if (rd_data !== 64'h0) begin
         n_fail++; $display("FAIL r0_after_write: got %h want 0", rd_data);
      end
      tick();
      n_tests++;
      if (dbg_data !== 32'h0) begin
         n_fail++; $display("FAIL r0_dbg: got %h want 0", dbg_data);
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_0001;
      rd_addr = {5'd10, 5'd7};
      dbg_addr = 5'd7;
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL bypass_p0: got %h want a5a50001", rd_data[31:0]);
      end
      n_tests++;
      if (rd_data[63:32] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL bypass_p1_other: got %h want deadbeef", rd_data[63:32]);
      end
      tick();
      wr_en = 1'b0;
      #1;
      n_tests++;
      if (dbg_data !== 32'h0) begin
         n_fail++; $display("FAIL bypass_dbg_old: got %h want 0", dbg_data);
      end
      n_tests++;
      if (rd_data[31:0] !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL bypass_stored: got %h want a5a50001", rd_data[31:0]);
      end
      tick();
      n_tests++;
      if (dbg_data !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL bypass_dbg_new: got %h want a5a50001", dbg_data);
      end
   endtask

   task automatic test_scoreboard();
      rd_addr = {5'd4, 5'd3};
      iss_en = 1'b1; iss_addr = 5'd3;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_before_iss: got %b want 0", rd_busy[0]);
      end
      tick();
      iss_en = 1'b0;
      #1;
      n_tests++;
      if (rd_busy !== 2'b01) begin
         n_fail++; $display("FAIL sb_after_iss: got %b want 01", rd_busy);
      end
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0000_0033) begin
         n_fail++; $display("FAIL sb_wb_mask: got busy %b data %h want 0 00000033", rd_busy[0], rd_data[31:0]);
      end
      tick();
      wr_en = 1'b0;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_cleared: got %b want 0", rd_busy[0]);
      end
      // Re-issue, then issue and write back together: new writer wins.
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0044;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_both_mask: got %b want 0", rd_busy[0]);
      end
      tick();
      iss_en = 1'b0; wr_en = 1'b0;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL sb_both_keep: got %b want 1", rd_busy[0]);
      end
      // Write to a non-busy register leaves it idle; r3 stays busy.
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0055;
      tick();
      wr_en = 1'b0;
      #1;
      n_tests++;
      if (rd_busy !== 2'b01) begin
         n_fail++; $display("FAIL sb_nonbusy_wr: got %b want 01", rd_busy);
      end
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0066;
      iss_en = 1'b1; iss_addr = 5'd0;
      tick();
      wr_en = 1'b0; iss_en = 1'b0;
      rd_addr = {5'd0, 5'd3};
      #1;
      n_tests++;
      if (rd_busy !== 2'b00) begin
         n_fail++; $display("FAIL sb_final_and_r0: got %b want 00", rd_busy);
      end
   endtask

   task automatic test_reset_mid_sweep();
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h0000_FFFF;
      dbg_addr = 5'd20;
      tick();
      wr_en = 1'b0;
      tick();
      n_tests++;
      if (dbg_data !== 32'h0000_FFFF) begin
         n_fail++; $display("FAIL mid_pre_r20: got %h want 0000ffff", dbg_data);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      rd_addr = {5'd20, 5'd29};
      #1;
      n_tests++;
      if (ready !== 1'b0 || rd_busy !== 2'b11 || rd_data !== 64'h0) begin
         n_fail++; $display("FAIL mid_clear_view: got ready %b busy %b data %h want 0 11 0", ready, rd_busy, rd_data);
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_ready: got %b want 0", ready);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         tick();
         n_tests++;
         if (ready !== (e == 32)) begin
            n_fail++; $display("FAIL mid_ready edge %0d: got %b want %b", e, ready, (e == 32));
         end
      end
      n_tests++;
      if (rd_data[63:32] !== 32'h0 || rd_data[31:0] !== 32'h0000_2FFC) begin
         n_fail++; $display("FAIL mid_after: got r20 %h r29 %h want 0 00002ffc", rd_data[63:32], rd_data[31:0]);
      end
   endtask

   task automatic test_param_sweep();
      b_rst_n = 1'b0;
      tick();
      b_rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_tests++;
         if (b_ready !== (e == 8)) begin
            n_fail++; $display("FAIL b_ready edge %0d: got %b want %b", e, b_ready, (e == 8));
         end
      end
      b_rd_addr = {3'd5, 3'd0, 3'd2};
      #1;
      n_tests++;
      if (b_rd_data !== {32'h0, 32'h0, 32'h0000_2FFC}) begin
         n_fail++; $display("FAIL b_init: got %h want 0 0 00002ffc", b_rd_data);
      end
      b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 32'h0000_0022;
      b_rd_addr = {3'd7, 3'd0, 3'd2};
      #1;
      n_tests++;
      if (b_rd_data[63:32] !== 32'h0000_0022) begin
         n_fail++; $display("FAIL b_r0_bypass: got %h want 00000022", b_rd_data[63:32]);
      end
      tick();
      b_wr_addr = 3'd5; b_wr_data = 32'h0000_0055;
      tick();
      b_wr_addr = 3'd7; b_wr_data = 32'h0000_0077;
      tick();
      b_wr_en = 1'b0;
      b_rd_addr = {3'd7, 3'd5, 3'd0};
      #1;
      n_tests++;
      if (b_rd_data !== {32'h0000_0077, 32'h0000_0055, 32'h0000_0022}) begin
         n_fail++; $display("FAIL b_three_ports: got %h want 00000077 00000055 00000022", b_rd_data);
      end
      b_iss_en = 1'b1; b_iss_addr = 3'd0;
      tick();
      b_iss_en = 1'b0;
      #1;
      n_tests++;
      if (b_rd_busy !== 3'b001) begin
         n_fail++; $display("FAIL b_r0_busy: got %b want 001", b_rd_busy);
      end
   endtask

   initial begin
      rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; dbg_addr = '0;
      b_rst_n = 1'b0; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      b_iss_en = 1'b0; b_iss_addr = '0; b_dbg_addr = '0;
      test_reset();
      test_write_zero();
      test_bypass();
      test_scoreboard();
      test_reset_mid_sweep();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Configurable width, depth and read-port count.
- Adds a write-to-read bypass, a per-register pending-write scoreboard, a sequential post-reset clear/init sweep with a stack-pointer preset, and a registered debug read port that replaces simulation prints.
- Sits in the decode stage of the pipelined core: feeds operands and hazard status to the issue logic.

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; must be a power of 2 and at least 4
- NRD, 2, number of combinational read ports
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never busy
- SP_REG, 29, index preset to SP_INIT by the clear sweep
- SP_INIT, 32'h0000_2FFC, stack-pointer init value; all other registers init to 0
- AW, log2(NREGS), derived address width; not overridable

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- ready  out  1  1 when the clear sweep is done and the file accepts traffic
- rd_addr  in  NRD*AW  packed read addresses; port i occupies [i*AW +: AW]
- rd_data  out  NRD*DATA_W  packed read data
- rd_busy  out  NRD  1 = the addressed register has a pending writer
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back register
- wr_data  in  DATA_W  write-back data
- iss_en  in  1  an instruction issued that will write iss_addr
- iss_addr  in  AW  destination of the issued instruction
- dbg_addr  in  AW  debug read address
- dbg_data  out  DATA_W  registered debug read data

Behaviour:
- Reset: any clock edge with rst_n=0 sets
  - state to CLEAR, ptr to 0
  - busy[] to all 0, ready to 0, dbg_data to 0
  - Register contents are not reset directly; the sweep initialises them.
- CLEAR state:
  - Each edge writes rh[ptr] = (ptr==SP_REG) ? SP_INIT : 0, then ptr increments.
  - On the edge that writes ptr==NREGS-1, the state moves to RUN and ready goes to 1.
  - ready is therefore 1 after exactly NREGS edges with rst_n=1.
  - wr_en and iss_en are ignored during CLEAR.
  - rd_data reads 0 and rd_busy reads all 1 during CLEAR.
  - rst_n low mid-sweep restarts the sweep at ptr 0.
- RUN, write:
  - On an edge with wr_en=1, rh[wr_addr] <= wr_data.
  - The write is suppressed when ZERO_REG=1 and wr_addr==0.
- RUN, read (combinational, per port i):
  - addr==0 with ZERO_REG=1 -> 0.
  - Else wr_en=1 and wr_addr==addr -> wr_data (bypass).
  - Else -> rh[addr].
- Scoreboard, next value of busy[r]:
  - Set when iss_en=1 and iss_addr==r.
  - Else cleared when wr_en=1 and wr_addr==r.
  - Else held.
  - Simultaneous issue and write-back to the same register leaves busy=1: the new writer wins.
  - Register 0 is never set when ZERO_REG=1.
  - A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i]:
  - busy[addr] & ~(wr_en & wr_addr==addr): a bypassed write-back makes the operand valid this cycle.
  - Forced 0 for register 0 when ZERO_REG=1.
- Debug port:
  - dbg_data <= rh[dbg_addr] each edge in RUN; 1-cycle latency.
  - No bypass; it returns the pre-write value when dbg_addr is written on the same edge.
  - Held at 0 during CLEAR.
- Width rules:
  - No arithmetic beyond ptr increment; ptr is AW bits.
  - The sweep termination compare uses NREGS-1, so ptr never wraps.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, RUN}
  - default constants: DATA_W, NREGS, SP_REG, SP_INIT
  - clog2-based AW helper function
- Sub-module regfile_sb_rdport: one combinational read path (zero, bypass and busy masking), instantiated NRD times via generate.
- Top level holds the storage array, the sweep FSM, the scoreboard and the debug register.

Test Plan:
- Reset release:
  - Stimulus: hold rst_n=0 for 3 edges, then release.
  - Required: ready=0 for 31 edges and 1 after the 32nd; reg 29 reads 32'h0000_2FFC; regs 5 and 31 read 0; rd_busy=0.
- Basic write and zero register:
  - Stimulus: write 32'hDEAD_BEEF to r10, then read r10 on port 1.
  - Required: port 1 = DEADBEEF.
  - Stimulus: write 32'h1234 to r0, then read r0.
  - Required: r0 = 0 on both ports.
- Bypass:
  - Stimulus: same cycle wr_en=1, wr_addr=7, wr_data=32'hA5A5_0001, rd_addr port 0=7.
  - Required: rd_data port 0 = A5A50001 combinationally; dbg_data for r7 on that edge = old value 0.
- Scoreboard:
  - Stimulus: iss r3.
  - Required: next cycle rd_busy=1.
  - Stimulus: write-back r3 while reading r3.
  - Required: rd_busy=0 in that cycle; busy=0 after the edge.
  - Stimulus: iss r3 and write-back r3 simultaneously.
  - Required: busy remains 1.
- Reset mid-sweep:
  - Stimulus: drop rst_n for 1 edge at sweep cycle 10.
  - Required: ready stays 0 until 32 edges after re-release; an earlier write of 0xFFFF to r20 is cleared to 0.
- Parameter sweep:
  - Configuration: NREGS=8, NRD=3, ZERO_REG=0, SP_REG=2.
  - Required: ready after 8 edges; r2 = SP_INIT; r0 is writable; all 3 ports read independently.
